// File: rtl/parity_frame_if.sv
// Producer-side frame handshake and result strobe for parity_frame_ctrl.
interface parity_frame_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_par;
  logic             out_valid;
  logic             out_par;
  logic             out_err;

  // Producer / result consumer side
  modport master (
    output in_valid, in_data, in_par,
    input  in_ready, out_valid, out_par, out_err
  );

  // Frame controller side
  modport slave (
    input  in_valid, in_data, in_par,
    output in_ready, out_valid, out_par, out_err
  );
endinterface

// File: rtl/parity_frame_ctrl.sv
// Frame sequencer for the bit-serial Mealy parity checker: shifts a word
// LSB-first into the checker, samples its parity on the last bit, reports
// the result, then pulses the checker's reset so every frame starts EVEN.
module parity_frame_ctrl #(
  parameter int unsigned WIDTH = 8,
  parameter bit          ODD   = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  parity_frame_if.slave        bus,
  output logic                 chk_x,
  output logic                 chk_rst,
  input  logic                 chk_z,
  output logic                 busy,
  output logic [7:0]           err_count
);

  localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam int unsigned ERR_W = 8;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};

  typedef enum logic [1:0] {IDLE, SHIFT, CLEAR} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   shift_q, shift_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               par_lat_q, par_lat_d;
  logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;
  logic               in_ready_q, in_ready_d;
  logic               busy_q, busy_d;
  logic               out_valid_q, out_valid_d;
  logic               out_par_q, out_par_d;
  logic               out_err_q, out_err_d;
  logic               chk_x_q, chk_x_d;
  logic               clr_q, clr_d;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next state, datapath next values and registered output decode
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    par_lat_d = par_lat_q;
    err_cnt_d = err_cnt_q;
    out_par_d = 1'b0;
    out_err_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          shift_d   = bus.in_data;
          par_lat_d = bus.in_par;
          cnt_d     = '0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        shift_d = shift_q >> 1;
        cnt_d   = cnt_q + CNT_W'(1);
        // chk_z already includes the bit on chk_x this cycle
        if (cnt_q == LAST_BIT) begin
          out_par_d = chk_z;
          out_err_d = chk_z ^ par_lat_q ^ ODD;
          cnt_d     = '0;
          state_d   = CLEAR;
        end
      end
      CLEAR: begin
        if (out_err_q && (err_cnt_q != ERR_MAX)) err_cnt_d = err_cnt_q + ERR_W'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    in_ready_d  = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
    out_valid_d = (state_d == CLEAR);
    clr_d       = (state_d == CLEAR);
    chk_x_d     = (state_d == SHIFT) ? shift_d[0] : 1'b0;
  end

  // Datapath and output flops
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_q     <= '0;
      cnt_q       <= '0;
      par_lat_q   <= 1'b0;
      err_cnt_q   <= '0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_par_q   <= 1'b0;
      out_err_q   <= 1'b0;
      chk_x_q     <= 1'b0;
      clr_q       <= 1'b0;
    end else begin
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      par_lat_q   <= par_lat_d;
      err_cnt_q   <= err_cnt_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      out_par_q   <= out_par_d;
      out_err_q   <= out_err_d;
      chk_x_q     <= chk_x_d;
      clr_q       <= clr_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_par   = out_par_q;
  assign bus.out_err   = out_err_q;
  assign busy          = busy_q;
  assign err_count     = err_cnt_q;
  assign chk_x         = chk_x_q;
  // Checker is held in reset through our own reset as well as the CLEAR pulse
  assign chk_rst       = clr_q | ~rst;

endmodule

// File: doc/parity_frame_ctrl.md
# parity_frame_ctrl

Frame-level sequencer for the bit-serial Mealy parity checker. Accepts a parallel data word plus its transmitted parity bit over a valid/ready handshake, and shifts the word LSB-first into the checker. It captures the checker's combinational parity output on the last data bit and reports a parity result and error flag. It then clears the checker so the next frame starts from the EVEN state. The block sits between a word-oriented producer and the serial checker and owns all sequencing of it.

## Interface
- WIDTH, 8, data bits per frame (≥2)
- ODD, 0, parity mode: 0 = even parity expected, 1 = odd parity expected
- clk  in  1  clock, all flops on rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  producer has a frame on in_data/in_par
- in_ready  out  1  block can accept a frame
- in_data  in  WIDTH  frame data, bit 0 shifted first
- in_par  in  1  transmitted parity bit for the frame
- chk_x  out  1  serial bit to checker input x
- chk_rst  out  1  active-high reset to checker (checker's rst)
- chk_z  in  1  checker Mealy output z (running parity including current chk_x)
- out_valid  out  1  one-cycle result strobe
- out_par  out  1  computed parity of in_data (1 = odd number of ones)
- out_err  out  1  parity mismatch, valid with out_valid
- busy  out  1  frame in progress (state ≠ IDLE)
- err_count  out  8  saturating count of frames with out_err=1

## Operation
- States: IDLE, SHIFT, CLEAR. Reset state IDLE.
- IDLE: in_ready=1. When in_valid=1, load in_data into shift register, latch in_par, set bit counter to 0, and go to SHIFT.
- SHIFT: chk_x = shift_reg[0]. Each cycle, shift right by 1 and increment the counter. In the cycle with counter = WIDTH-1, capture chk_z into par_q and go to CLEAR.
- CLEAR: assert the chk_rst flop. out_valid=1, out_par=par_q, out_err = par_q ^ par_latched ^ ODD. If out_err=1, increment err_count, holding it at 255. Go to IDLE.
- chk_x=0 in IDLE and CLEAR. chk_z is ignored outside the last SHIFT cycle.
- chk_rst = clr_q OR (rst==0). clr_q is a flop that is 1 only during the CLEAR cycle. It is registered, so no glitches reach the checker's async reset.
- in_ready=0 in SHIFT and CLEAR. in_data and in_par are don't-care after acceptance.
- Reset values: state IDLE, in_ready 1 (after release), busy 0, chk_x 0, chk_rst 1 while rst=0, then 0, out_valid 0, out_par 0, out_err 0, err_count 0, all internal registers 0.
- Reset mid-frame: abort immediately to IDLE with no out_valid. The checker is held in reset by chk_rst, so it resumes from EVEN. err_count clears.

## Timing
- Handshake edge is T0 (in_valid & in_ready). SHIFT runs cycles T0+1 … T0+WIDTH, presenting bit i in cycle T0+1+i.
- par_q is captured at the end of cycle T0+WIDTH.
- CLEAR is cycle T0+WIDTH+1: out_valid, out_par, out_err and chk_rst are high and valid for exactly this cycle. err_count updates at the end of this cycle.
- Back to IDLE at T0+WIDTH+2. A frame held on in_valid is accepted in that cycle.
- Peak throughput is one frame per WIDTH+2 cycles. Latency from acceptance to out_valid is WIDTH+1 cycles.
- err_count saturates: at 255, an error frame leaves it at 255.

## Test plan
- ODD=0, WIDTH=8, in_data=0xA5, in_par=0 → chk_x sequence 1,0,1,0,0,1,0,1. out_valid in cycle T0+9 with out_par=0, out_err=0, err_count=0.
- ODD=0, in_data=0x01, in_par=0 → out_par=1, out_err=1, err_count=1. chk_rst pulses for one cycle and the checker returns to EVEN.
- ODD=1, in_data=0x03, in_par=1 → out_par=0, out_err=0. Same data with in_par=0 → out_err=1.
- in_valid held high with frames 0xFF/par0, then 0x7F/par1 → accepts at T0 and T0+10, two out_valid strobes 10 cycles apart, both out_err=0.
- Assert rst=0 in the 4th SHIFT cycle → no out_valid, chk_rst=1 during reset. After release, in_ready=1 and err_count=0. The next frame 0x01/par1 gives out_err=0.
- 260 consecutive error frames → err_count reaches 255 and stays at 255.
